// File: rtl/icache_refill_unit_pkg.sv
// Shared types and constants for the instruction-cache refill unit:
// FSM state encoding, line geometry defaults and the line-alignment helper.
package icache_refill_unit_pkg;

    localparam int unsigned LINE_SIZE    = 512;
    localparam int unsigned BEAT_WIDTH   = 64;
    localparam int unsigned OFFSET_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BEAT = 2'd2,
        ST_RESP = 2'd3
    } refill_state_e;

    // Clear the byte-offset bits so the address names the start of its line.
    function automatic logic [63:0] line_align(input logic [63:0] addr,
                                               input int unsigned off_w);
        logic [63:0] mask;
        mask = '1;
        mask = mask << off_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/miss_addr_fifo.sv
// In-order queue of pending line-miss addresses.
// Head entry is readable combinationally; count is registered so the
// upstream ready can be derived without a path from the pop side.
module miss_addr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/icache_refill_unit.sv
// Memory-side refill responder for the instruction cache.
// Queues line misses, fetches each line as BEATS response beats, and returns
// exactly one refill per accepted miss in acceptance order.
// Optional last-line buffer: define ICACHE_REFILL_LINE_BUF_EN to enable it.
module icache_refill_unit #(
    parameter int unsigned LINE_SIZE    = icache_refill_unit_pkg::LINE_SIZE,
    parameter int unsigned BEAT_WIDTH   = icache_refill_unit_pkg::BEAT_WIDTH,
    parameter int unsigned OFFSET_WIDTH = icache_refill_unit_pkg::OFFSET_WIDTH,
    parameter int unsigned MISS_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_miss_valid_i,
    output logic                  icache_miss_ready_o,
    input  logic [63:0]           icache_miss_addr_i,
    output logic                  refill_icache_valid_o,
    input  logic                  refill_icache_ready_i,
    output logic [LINE_SIZE-1:0]  refill_icache_data_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [63:0]           mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [BEAT_WIDTH-1:0] mem_resp_data_i,
    input  logic                  fence_i_i
);

    import icache_refill_unit_pkg::*;

    localparam int unsigned BEATS      = LINE_SIZE / BEAT_WIDTH;
    localparam int unsigned BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W      = $clog2(MISS_DEPTH) + 1;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    refill_state_e          state_q, state_d;
    logic [BEAT_CNT_W-1:0]  beat_q, beat_d;
    logic [LINE_SIZE-1:0]   line_q, line_d;

    logic                   fifo_push, fifo_pop;
    logic                   fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [63:0]            head_addr;

    logic                   lb_hit;
    logic [LINE_SIZE-1:0]   hit_line;

    assign icache_miss_ready_o  = (fifo_count < CNT_W'(MISS_DEPTH));
    assign fifo_push            = icache_miss_valid_i && !fifo_full;
    assign refill_icache_data_o = line_q;

    miss_addr_fifo #(
        .DEPTH (MISS_DEPTH),
        .WIDTH (64)
    ) u_miss_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  (line_align(icache_miss_addr_i, OFFSET_WIDTH)),
        .pop_i   (fifo_pop),
        .data_o  (head_addr),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef ICACHE_REFILL_LINE_BUF_EN
    logic                 lb_valid_q, lb_valid_d;
    logic [63:0]          lb_addr_q, lb_addr_d;
    logic [LINE_SIZE-1:0] lb_data_q, lb_data_d;

    // A fence in the same cycle as the head check must not serve stale data.
    assign lb_hit   = lb_valid_q && !fence_i_i && (lb_addr_q == head_addr);
    assign hit_line = lb_data_q;

    // Capture each memory-fetched line as it completes; fence wins over capture.
    always_comb begin
        lb_valid_d = lb_valid_q;
        lb_addr_d  = lb_addr_q;
        lb_data_d  = lb_data_q;
        if ((state_q == ST_BEAT) && (state_d == ST_RESP)) begin
            lb_valid_d = 1'b1;
            lb_addr_d  = head_addr;
            lb_data_d  = line_d;
        end
        if (fence_i_i) begin
            lb_valid_d = 1'b0;
        end
    end

    // Line buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_valid_q <= 1'b0;
            lb_addr_q  <= '0;
            lb_data_q  <= '0;
        end else begin
            lb_valid_q <= lb_valid_d;
            lb_addr_q  <= lb_addr_d;
            lb_data_q  <= lb_data_d;
        end
    end
`else
    logic unused_fence;

    assign lb_hit       = 1'b0;
    assign hit_line     = '0;
    assign unused_fence = fence_i_i;
`endif

    // Refill sequencing: request, beat assembly, and refill handoff.
    always_comb begin
        state_d               = state_q;
        beat_d                = beat_q;
        line_d                = line_q;
        fifo_pop              = 1'b0;
        mem_req_valid_o       = 1'b0;
        mem_req_addr_o        = '0;
        refill_icache_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (lb_hit) begin
                        line_d  = hit_line;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = head_addr;
                if (mem_req_ready_i) begin
                    beat_d  = '0;
                    state_d = ST_BEAT;
                end
            end
            ST_BEAT: begin
                if (mem_resp_valid_i) begin
                    line_d[beat_q*BEAT_WIDTH +: BEAT_WIDTH] = mem_resp_data_i;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + BEAT_CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                refill_icache_valid_o = 1'b1;
                if (refill_icache_ready_i) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, beat counter and assembled line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Self-checking bench for icache_refill_unit: directed scenarios plus random
// traffic against a queue-based reference model of misses, memory and refills.
module tb_icache_refill_unit;

    localparam int unsigned BEATS = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         icache_miss_valid_i = 1'b0;
    logic         icache_miss_ready_o;
    logic [63:0]  icache_miss_addr_i = '0;
    logic         refill_icache_valid_o;
    logic         refill_icache_ready_i = 1'b0;
    logic [511:0] refill_icache_data_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b0;
    logic [63:0]  mem_req_addr_o;
    logic         mem_resp_valid_i = 1'b0;
    logic [63:0]  mem_resp_data_i = '0;
    logic         fence_i_i = 1'b0;

    icache_refill_unit #(
        .LINE_SIZE    (512),
        .BEAT_WIDTH   (64),
        .OFFSET_WIDTH (6),
        .MISS_DEPTH   (4)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .icache_miss_valid_i   (icache_miss_valid_i),
        .icache_miss_ready_o   (icache_miss_ready_o),
        .icache_miss_addr_i    (icache_miss_addr_i),
        .refill_icache_valid_o (refill_icache_valid_o),
        .refill_icache_ready_i (refill_icache_ready_i),
        .refill_icache_data_o  (refill_icache_data_o),
        .mem_req_valid_o       (mem_req_valid_o),
        .mem_req_ready_i       (mem_req_ready_i),
        .mem_req_addr_o        (mem_req_addr_o),
        .mem_resp_valid_i      (mem_resp_valid_i),
        .mem_resp_data_i       (mem_resp_data_i),
        .fence_i_i             (fence_i_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: accepted misses in order, the line being returned by
    // memory, and the last memory-fetched line (for the buffered build).
    logic [63:0]  pend[$];
    int           beats_left = 0;
    int           beat_idx = 0;
    logic [511:0] exp_line = '0;
    logic         served_by_mem = 1'b0;
    logic         lb_valid_m = 1'b0;
    logic [63:0]  lb_addr_m = '0;
    logic [511:0] lb_data_m = '0;

    // Traffic knobs (percent probabilities).
    int p_req_ready = 100;
    int p_beat = 100;
    int p_refill_ready = 100;
    int p_stray = 0;
    bit beat_seq = 1'b0;

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic model_hit();
        return (pend.size() != 0) && lb_valid_m && (lb_addr_m == pend[0]);
    endfunction

    task automatic drive_mem();
        mem_req_ready_i       = ($urandom_range(99) < p_req_ready);
        refill_icache_ready_i = ($urandom_range(99) < p_refill_ready);
        if (beats_left > 0) mem_resp_valid_i = ($urandom_range(99) < p_beat);
        else                mem_resp_valid_i = ($urandom_range(99) < p_stray);
        if (beat_seq && beats_left > 0) mem_resp_data_i = 64'(beat_idx);
        else                            mem_resp_data_i = {$urandom, $urandom};
    endtask

    // Resolve this cycle's handshakes against the model, then advance a clock.
    task automatic tick();
        check_eq("miss_ready", 512'(icache_miss_ready_o), 512'(pend.size() < 4));
        if (mem_resp_valid_i && beats_left > 0) begin
            exp_line[beat_idx*64 +: 64] = mem_resp_data_i;
            beat_idx++;
            beats_left--;
            if (beats_left == 0) begin
`ifdef ICACHE_REFILL_LINE_BUF_EN
                lb_valid_m = 1'b1;
                lb_addr_m  = pend[0];
                lb_data_m  = exp_line;
`endif
            end
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
            check_eq("req_queue_nonempty", 512'(pend.size() != 0), 512'(1));
            if (pend.size() != 0) begin
                check_eq("req_addr", 512'(mem_req_addr_o), 512'(pend[0]));
                check_eq("req_on_lb_hit", 512'(model_hit()), 512'(0));
            end
            beats_left    = BEATS;
            beat_idx      = 0;
            served_by_mem = 1'b1;
        end
        if (refill_icache_valid_o && refill_icache_ready_i) begin
            check_eq("refill_queue_nonempty", 512'(pend.size() != 0), 512'(1));
            if (pend.size() != 0) begin
                if (served_by_mem) begin
                    check_eq("refill_data", refill_icache_data_o, exp_line);
                end else begin
                    check_eq("refill_lb_hit", 512'(model_hit()), 512'(1));
                    check_eq("refill_lb_data", refill_icache_data_o, lb_data_m);
                end
                void'(pend.pop_front());
            end
            served_by_mem = 1'b0;
        end
        if (icache_miss_valid_i && icache_miss_ready_o) begin
            pend.push_back({icache_miss_addr_i[63:6], 6'b0});
        end
`ifdef ICACHE_REFILL_LINE_BUF_EN
        if (fence_i_i) lb_valid_m = 1'b0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n                 = 1'b0;
        icache_miss_valid_i   = 1'b0;
        refill_icache_ready_i = 1'b0;
        mem_req_ready_i       = 1'b0;
        mem_resp_valid_i      = 1'b0;
        fence_i_i             = 1'b0;
        #1;
        check_eq("rst_miss_ready", 512'(icache_miss_ready_o), 512'(1));
        check_eq("rst_refill_valid", 512'(refill_icache_valid_o), 512'(0));
        check_eq("rst_refill_data", refill_icache_data_o, 512'(0));
        check_eq("rst_req_valid", 512'(mem_req_valid_o), 512'(0));
        check_eq("rst_req_addr", 512'(mem_req_addr_o), 512'(0));
        pend.delete();
        beats_left    = 0;
        beat_idx      = 0;
        served_by_mem = 1'b0;
        lb_valid_m    = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_miss(input logic [63:0] addr);
        icache_miss_valid_i = 1'b1;
        icache_miss_addr_i  = addr;
        drive_mem();
        tick();
        icache_miss_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!(pend.size() == 0 && beats_left == 0) && n < budget) begin
            drive_mem();
            tick();
            n++;
        end
        check_eq(tag, 512'(pend.size()), 512'(0));
    endtask

    task automatic wait_refill_valid(output int n, input int budget);
        n = 0;
        while (!refill_icache_valid_o && n < budget) begin
            drive_mem();
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int           n;
        logic [511:0] t1_exp;
        logic [511:0] hold_data;
        logic [63:0]  hold_addr;
        logic         seen_req;
        logic [63:0]  pool [4];

        #2;
        do_reset();

        // Single miss, sequential beat data, minimum latency.
        p_req_ready = 100; p_beat = 100; p_refill_ready = 0; p_stray = 0; beat_seq = 1'b1;
        push_miss(64'h8000_1234);
        n = 0;
        while (!refill_icache_valid_o && n < 40) begin
            drive_mem();
            if (mem_req_valid_o) check_eq("t1_req_addr", 512'(mem_req_addr_o), 512'(64'h8000_1200));
            tick();
            n++;
        end
        check_eq("t1_latency", 512'(n), 512'(10));
        for (int k = 0; k < 8; k++) t1_exp[k*64 +: 64] = 64'(k);
        check_eq("t1_data", refill_icache_data_o, t1_exp);
        p_refill_ready = 100;
        drain("t1_drain", 20);
        beat_seq = 1'b0;

        // Fill the queue while memory stalls, then release.
        p_req_ready = 0; p_refill_ready = 100;
        for (int i = 0; i < 4; i++) push_miss({$urandom, $urandom});
        check_eq("t2_ready_full", 512'(icache_miss_ready_o), 512'(0));
        check_eq("t2_req_pending", 512'(mem_req_valid_o), 512'(1));
        hold_addr = mem_req_addr_o;
        for (int i = 0; i < 3; i++) begin
            drive_mem();
            tick();
            check_eq("t2_req_addr_stable", 512'(mem_req_addr_o), 512'(hold_addr));
        end
        p_req_ready = 100; p_beat = 60;
        drain("t2_drain", 400);

        // Hold the refill for 5 cycles with another miss waiting.
        p_beat = 100; p_refill_ready = 0;
        push_miss({$urandom, $urandom});
        wait_refill_valid(n, 40);
        hold_data = refill_icache_data_o;
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_valid_held", 512'(refill_icache_valid_o), 512'(1));
            check_eq("t3_data_held", refill_icache_data_o, hold_data);
            check_eq("t3_no_req", 512'(mem_req_valid_o), 512'(0));
            if (i == 0) push_miss({$urandom, $urandom});
            else begin drive_mem(); tick(); end
        end
        p_refill_ready = 100;
        drain("t3_drain", 60);

        // Push and refill-pop together at occupancy 2.
        p_refill_ready = 0;
        push_miss(64'h0000_1000);
        push_miss(64'h0000_2000);
        wait_refill_valid(n, 40);
        p_refill_ready = 100;
        push_miss(64'h0000_3000);
        p_refill_ready = 0; p_req_ready = 0;
        check_eq("t4_ready_after_swap", 512'(icache_miss_ready_o), 512'(1));
        push_miss(64'h0000_4000);
        check_eq("t4_ready_at_3", 512'(icache_miss_ready_o), 512'(1));
        push_miss(64'h0000_5000);
        check_eq("t4_ready_at_4", 512'(icache_miss_ready_o), 512'(0));
        p_req_ready = 100; p_refill_ready = 100;
        drain("t4_drain", 200);

        // Reset in the middle of a burst, stray beats afterwards.
        push_miss(64'h8000_1234);
        n = 0;
        while (beat_idx < 3 && n < 20) begin
            p_beat = (beats_left > 0 && beat_idx == 3) ? 0 : 100;
            drive_mem();
            tick();
            n++;
        end
        do_reset();
        p_stray = 100;
        for (int i = 0; i < 4; i++) begin drive_mem(); tick(); end
        p_stray = 30;
        push_miss(64'h8000_5678);
        drain("t5_drain", 60);

        // Random traffic over a small address pool.
        pool[0] = 64'h8000_1200; pool[1] = 64'h8000_1240;
        pool[2] = 64'h0000_0040; pool[3] = 64'hFFFF_FFC0;
        p_stray = 20;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                p_req_ready    = $urandom_range(30, 100);
                p_beat         = $urandom_range(30, 100);
                p_refill_ready = $urandom_range(30, 100);
            end
            icache_miss_valid_i = ($urandom_range(99) < 40);
            icache_miss_addr_i  = pool[$urandom_range(3)] | 64'($urandom_range(63));
            drive_mem();
            tick();
        end
        icache_miss_valid_i = 1'b0;
        p_req_ready = 100; p_beat = 100; p_refill_ready = 100;
        drain("t6_drain", 300);

`ifdef ICACHE_REFILL_LINE_BUF_EN
        // Repeat miss served from the line buffer; fence forces a refetch.
        do_reset();
        p_stray = 0;
        push_miss(64'h8000_1200);
        drain("t7_first", 40);
        p_refill_ready = 0;
        push_miss(64'h8000_1210);
        n = 0; seen_req = 1'b0;
        while (!refill_icache_valid_o && n < 20) begin
            if (mem_req_valid_o) seen_req = 1'b1;
            drive_mem();
            tick();
            n++;
        end
        check_eq("t7_hit_latency", 512'(n), 512'(1));
        check_eq("t7_hit_no_req", 512'(seen_req), 512'(0));
        p_refill_ready = 100;
        drain("t7_hit_drain", 20);
        fence_i_i = 1'b1;
        drive_mem();
        tick();
        fence_i_i = 1'b0;
        push_miss(64'h8000_1200);
        n = 0; seen_req = 1'b0;
        while (!refill_icache_valid_o && n < 20) begin
            if (mem_req_valid_o) seen_req = 1'b1;
            drive_mem();
            tick();
            n++;
        end
        check_eq("t7_fence_refetch", 512'(seen_req), 512'(1));
        drain("t7_fence_drain", 20);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
